// File: rtl/digit_pkg.sv
// Shared constants and state encoding for the digit entry bank.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package digit_pkg;

  localparam int N_DIGITS = 8;
  localparam int DW       = 4;

  // Largest legal decimal digit when BCD checking is built in.
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ENTRY  = 2'd1,
    FULL   = 2'd2,
    LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/digit_entry_bank.sv
// Calculator-style digit entry bank feeding the 8-digit display selector.
// Latency: every event at edge n is visible on the registered outputs after edge n.
// Backpressure: din_ready drops while FULL or LOCKED; digits offered then are dropped.
//
// Ports:
//   clk, rst              clock (rising edge) and asynchronous active-high reset
//   din_valid, din        digit strobe and value; taken only when din_ready=1
//   din_ready             bank accepts a digit this cycle
//   bksp, clr, commit     delete newest digit / clear and unlock / freeze contents
//   digits_o              flattened bank, digit k at digits_o[k*DW +: DW]
//   count                 number of valid digits, 0..N_DIGITS
//   locked                bank is frozen after a commit
//   commit_p              one-cycle pulse in the cycle after a commit is taken
//   ovf                   sticky: a digit was offered while FULL; cleared by clr
//   err                   one-cycle pulse when a digit is rejected as non-BCD
//
// Build option BCD_CHECK_EN: when defined, digits above 9 are rejected and pulse err;
// when undefined, every DW-bit value is accepted and err is tied low.
module digit_entry_bank #(
  parameter int N_DIGITS = digit_pkg::N_DIGITS,
  parameter int DW       = digit_pkg::DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din_valid,
  input  logic [DW-1:0]          din,
  output logic                   din_ready,
  input  logic                   bksp,
  input  logic                   clr,
  input  logic                   commit,
  output logic [N_DIGITS*DW-1:0] digits_o,
  output logic [3:0]             count,
  output logic                   locked,
  output logic                   commit_p,
  output logic                   ovf,
  output logic                   err
);

  import digit_pkg::*;

  state_e     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       commit_p_q, commit_p_d;

  logic       bcd_ok;
  logic       pri_free;
  logic       do_commit;
  logic       do_bksp;
  logic       do_push;
  logic       ovf_set;

  logic [N_DIGITS*DW-1:0] bank_q;

  // ------------------------------------------------------------------
  // Event arbitration: clr > commit > bksp > push. A raised higher-
  // priority request blocks lower ones even when it has no effect
  // itself (e.g. bksp in EMPTY still drops a same-cycle push).
  // ------------------------------------------------------------------
`ifdef BCD_CHECK_EN
  assign bcd_ok = (din <= DW'(BCD_MAX));
`else
  assign bcd_ok = 1'b1;
`endif

  assign din_ready = (state_q != FULL) && (state_q != LOCKED);
  assign pri_free  = !clr && !commit && !bksp;
  assign do_commit = !clr && commit && (state_q != LOCKED);
  assign do_bksp   = !clr && !commit && bksp &&
                     ((state_q == ENTRY) || (state_q == FULL));
  assign do_push   = pri_free && din_valid && din_ready && bcd_ok;
  // Offers while LOCKED are not overflow; only a FULL bank overflows.
  assign ovf_set   = pri_free && din_valid && (state_q == FULL);

  // ------------------------------------------------------------------
  // FSM, digit counter and status flags
  // ------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    ovf_d      = ovf_q || ovf_set;
    commit_p_d = 1'b0;
    if (clr) begin
      state_d = EMPTY;
      count_d = 4'd0;
      ovf_d   = 1'b0;
    end else if (do_commit) begin
      state_d    = LOCKED;
      commit_p_d = 1'b1;
    end else if (do_bksp) begin
      count_d = count_q - 4'd1;
      state_d = (count_q == 4'd1) ? EMPTY : ENTRY;
    end else if (do_push) begin
      count_d = count_q + 4'd1;
      state_d = (count_q == 4'(N_DIGITS - 1)) ? FULL : ENTRY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      count_q    <= 4'd0;
      ovf_q      <= 1'b0;
      commit_p_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      commit_p_q <= commit_p_d;
    end
  end

`ifdef BCD_CHECK_EN
  logic err_q, err_d;

  // A non-BCD digit that would otherwise have been pushed.
  assign err_d = pri_free && din_valid && din_ready && !bcd_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Digit shift register: push moves toward digit N-1, backspace moves
  // toward digit0 and fills the top slot with zero.
  // ------------------------------------------------------------------
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
    logic [DW-1:0] dig_q, dig_d;
    logic [DW-1:0] push_src, bksp_src;

    if (k == 0) begin : g_push_lo
      assign push_src = din;
    end else begin : g_push_hi
      assign push_src = bank_q[(k-1)*DW +: DW];
    end

    if (k == N_DIGITS - 1) begin : g_bksp_top
      assign bksp_src = '0;
    end else begin : g_bksp_mid
      assign bksp_src = bank_q[(k+1)*DW +: DW];
    end

    always_comb begin
      dig_d = dig_q;
      if (clr) begin
        dig_d = '0;
      end else if (do_bksp) begin
        dig_d = bksp_src;
      end else if (do_push) begin
        dig_d = push_src;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dig_q <= '0;
      end else begin
        dig_q <= dig_d;
      end
    end

    assign bank_q[k*DW +: DW] = dig_q;
  end

  assign digits_o = bank_q;
  assign count    = count_q;
  assign locked   = (state_q == LOCKED);
  assign commit_p = commit_p_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_digit_entry_bank.sv
module tb_digit_entry_bank;

  logic        clk;
  logic        rst;
  logic        din_valid;
  logic [3:0]  din;
  logic        din_ready;
  logic        bksp;
  logic        clr;
  logic        commit;
  logic [31:0] digits_o;
  logic [3:0]  count;
  logic        locked;
  logic        commit_p;
  logic        ovf;
  logic        err;

  int checks = 0;
  int errors = 0;

  digit_entry_bank dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din       (din),
    .din_ready (din_ready),
    .bksp      (bksp),
    .clr       (clr),
    .commit    (commit),
    .digits_o  (digits_o),
    .count     (count),
    .locked    (locked),
    .commit_p  (commit_p),
    .ovf       (ovf),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d);
    din = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_bksp();
    bksp = 1'b1;
    tick();
    bksp = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    din_valid = 1'b0;
    din = 4'd0;
    bksp = 1'b0;
    clr = 1'b0;
    commit = 1'b0;
    #12;
    chk("rst_digits", digits_o, 32'h0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_flags", {28'd0, locked, commit_p, ovf, err}, 32'd0);
    chk("rst_ready", {31'd0, din_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 1: push 1,2,3
    push(4'd1); push(4'd2); push(4'd3);
    chk("t1_digits", digits_o, 32'h00000123);
    chk("t1_count", {28'd0, count}, 32'd3);
    chk("t1_ready", {31'd0, din_ready}, 32'd1);
    chk("t1_locked", {31'd0, locked}, 32'd0);

    // 3: backspace down to empty and beyond
    do_bksp();
    chk("t3_bksp1", digits_o, 32'h00000012);
    chk("t3_count1", {28'd0, count}, 32'd2);
    do_bksp(); do_bksp();
    chk("t3_empty_digits", digits_o, 32'h0);
    chk("t3_empty_count", {28'd0, count}, 32'd0);
    do_bksp();
    chk("t3_extra_bksp", {digits_o[27:0], count}, 32'h0);

    // 4: clr beats a same-cycle push
    push(4'd1); push(4'd2);
    chk("t4_pre", digits_o, 32'h00000012);
    clr = 1'b1; din = 4'd5; din_valid = 1'b1;
    tick();
    clr = 1'b0; din_valid = 1'b0;
    chk("t4_clr_digits", digits_o, 32'h0);
    chk("t4_clr_count", {28'd0, count}, 32'd0);
    // commit beats a same-cycle backspace
    push(4'd1); push(4'd2); push(4'd3);
    commit = 1'b1; bksp = 1'b1;
    tick();
    commit = 1'b0; bksp = 1'b0;
    chk("t4_commit_digits", digits_o, 32'h00000123);
    chk("t4_commit_count", {28'd0, count}, 32'd3);
    chk("t4_locked", {31'd0, locked}, 32'd1);
    chk("t4_commit_p_hi", {31'd0, commit_p}, 32'd1);
    chk("t4_ready_locked", {31'd0, din_ready}, 32'd0);
    tick();
    chk("t4_commit_p_lo", {31'd0, commit_p}, 32'd0);

    // 5: locked ignores push/bksp/commit
    push(4'd7);
    chk("t5_push_digits", digits_o, 32'h00000123);
    chk("t5_push_ovf", {31'd0, ovf}, 32'd0);
    do_bksp();
    chk("t5_bksp_count", {28'd0, count}, 32'd3);
    do_commit();
    chk("t5_commit_p", {31'd0, commit_p}, 32'd0);
    chk("t5_still_locked", {31'd0, locked}, 32'd1);
    do_clr();
    chk("t5_clr_locked", {31'd0, locked}, 32'd0);
    chk("t5_clr_digits", digits_o, 32'h0);
    chk("t5_clr_ready", {31'd0, din_ready}, 32'd1);

    // 2: fill the bank, then overflow
    for (int i = 1; i <= 8; i++) push(4'(i));
    chk("t2_full_digits", digits_o, 32'h12345678);
    chk("t2_full_count", {28'd0, count}, 32'd8);
    chk("t2_full_ready", {31'd0, din_ready}, 32'd0);
    push(4'd9);
    chk("t2_ovf_digits", digits_o, 32'h12345678);
    chk("t2_ovf", {31'd0, ovf}, 32'd1);
    do_bksp();
    chk("t2_bksp_full", digits_o, 32'h01234567);
    chk("t2_bksp_count", {28'd0, count}, 32'd7);
    chk("t2_ovf_sticky", {31'd0, ovf}, 32'd1);
    chk("t2_ready_again", {31'd0, din_ready}, 32'd1);
    do_clr();
    chk("t2_ovf_cleared", {31'd0, ovf}, 32'd0);

    // asynchronous reset mid-entry
    push(4'd4); push(4'd5);
    chk("rst_pre", digits_o, 32'h00000045);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_digits", digits_o, 32'h0);
    chk("arst_count", {28'd0, count}, 32'd0);
    #2;
    rst = 1'b0;
    tick();

    // 6: non-BCD digit
    push(4'hA);
`ifdef BCD_CHECK_EN
    chk("t6_err_hi", {31'd0, err}, 32'd1);
    chk("t6_count", {28'd0, count}, 32'd0);
    chk("t6_digits", digits_o, 32'h0);
    tick();
    chk("t6_err_lo", {31'd0, err}, 32'd0);
`else
    chk("t6_digit0", digits_o, 32'h0000000A);
    chk("t6_count", {28'd0, count}, 32'd1);
    chk("t6_err", {31'd0, err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
